// File: rtl/round_sequencer.sv
// round_sequencer: launches each permutation stage in index order, waits for
// its done pulse, and repeats for NUM_ROUNDS rounds. It reports completion
// with a one-cycle done, or latches error on a timeout or a done from the
// wrong stage.
module round_sequencer #(
  parameter int NUM_ROUNDS = 24,
  parameter int NUM_STAGES = 5,
  parameter int RND_W      = 5,
  parameter int TIMEOUT    = 4095,
  localparam int SIDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int TMR_W     = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [RND_W-1:0]      round_idx,
  output logic [SIDX_W-1:0]     stage_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FIN,
    S_ERR
  } state_t;

  state_t                r_state;
  logic [RND_W-1:0]      r_round;
  logic [SIDX_W-1:0]     r_stage;
  logic [TMR_W-1:0]      r_timer;
  logic [NUM_STAGES-1:0] r_stage_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic [NUM_STAGES-1:0] w_sel;
  logic                  w_own_done;
  logic                  w_foreign_done;

  // One-hot select for a stage index.
  function automatic logic [NUM_STAGES-1:0] onehot(input logic [SIDX_W-1:0] idx);
    return NUM_STAGES'(1) << idx;
  endfunction

  // Split the done inputs into the expected stage and every other stage.
  always_comb begin
    w_sel          = onehot(r_stage);
    w_own_done     = |(stage_done & w_sel);
    w_foreign_done = |(stage_done & ~w_sel);
  end

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_round    <= '0;
      r_stage    <= '0;
      r_timer    <= '0;
      r_stage_en <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      // Enable and done are pulses; they are only raised on the edge that
      // enters ISSUE or FIN.
      r_stage_en <= '0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_round <= '0;
          r_stage <= '0;
          if (start) begin
            r_state    <= S_ISSUE;
            r_stage_en <= onehot('0);
            r_busy     <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // The expected done wins over a simultaneous timeout.
          if (w_own_done) begin
            r_state <= S_NEXT;
          end else if (w_foreign_done || (r_timer == TMR_W'(TIMEOUT))) begin
            r_state <= S_ERR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_NEXT: begin
          if (r_stage < SIDX_W'(NUM_STAGES - 1)) begin
            r_stage    <= r_stage + SIDX_W'(1);
            r_stage_en <= onehot(r_stage + SIDX_W'(1));
            r_state    <= S_ISSUE;
          end else if (r_round < RND_W'(NUM_ROUNDS - 1)) begin
            r_stage    <= '0;
            r_round    <= r_round + RND_W'(1);
            r_stage_en <= onehot('0);
            r_state    <= S_ISSUE;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          // Indices are cleared here so they already read zero in IDLE.
          r_round <= '0;
          r_stage <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          // Frozen until reset; start is deliberately ignored.
          r_state <= S_ERR;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign stage_en  = r_stage_en;
  assign round_idx = r_round;
  assign stage_idx = r_stage;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_round_sequencer.sv
// Testbench for round_sequencer: scheduled stage responders plus a
// scoreboard of expected enable/done/error events with their cycle numbers.
module tb_round_sequencer;
  localparam int NR = 2;
  localparam int NS = 2;
  localparam int RW = 2;
  localparam int TO = 16;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [NS-1:0] stage_done = '0;
  logic [NS-1:0] stage_en;
  logic [RW-1:0] round_idx;
  logic [SW-1:0] stage_idx;
  logic          busy, done, error;

  round_sequencer #(.NUM_ROUNDS(NR), .NUM_STAGES(NS), .RND_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .stage_done(stage_done),
    .stage_en(stage_en), .round_idx(round_idx), .stage_idx(stage_idx),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef enum int {EV_EN = 0, EV_DONE = 1, EV_ERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       stage;
    int       round;
    int       cyc;
  } ev_t;
  ev_t q[$];

  // Response delay per (round, stage) in WAIT cycles; 0 means never respond.
  int dly[NR][NS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input ev_kind_t k, input int s, input int r, input int c);
    ev_t e;
    e.kind = k; e.stage = s; e.round = r; e.cyc = c;
    q.push_back(e);
  endtask

  // Monitor: every visible event must match the head of the scoreboard.
  logic     prev_err = 1'b0;
  ev_t      mon_e;
  ev_kind_t mon_k;
  always @(negedge clk) begin
    if ((stage_en != '0) || done || (error && !prev_err)) begin
      mon_k = done ? EV_DONE : (error ? EV_ERR : EV_EN);
      if (q.size() == 0) begin
        chk("unexpected_event_kind", mon_k, 99);
      end else begin
        mon_e = q.pop_front();
        chk("ev_kind", mon_k, mon_e.kind);
        chk("ev_cycle", cyc, mon_e.cyc);
        chk("ev_round_idx", round_idx, mon_e.round);
        chk("ev_stage_idx", stage_idx, mon_e.stage);
        chk("ev_busy", busy, (mon_e.kind == EV_ERR) ? 0 : 1);
        if (mon_e.kind == EV_EN) begin
          chk("ev_stage_en", stage_en, NS'(1) << mon_e.stage);
          chk("ev_en_onehot", $countones(stage_en), 1);
        end else begin
          chk("ev_stage_en_zero", stage_en, 0);
        end
      end
    end
    prev_err <= error;
  end

  // Reference model and driver: walks rounds and stages by plain rules,
  // predicting each event's cycle. outcome: 0 done, 1 error, 2 reset.
  task automatic run_op(input int bad_r, input int bad_s, input int bad_w,
                        input int rst_r, output int outcome);
    outcome = 0;
    push(EV_EN, 0, 0, cyc + 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < NR; r++) begin
      for (int s = 0; s < NS; s++) begin
        // ISSUE cycle: any done bits here must be ignored.
        stage_done = NS'($urandom);
        tick();
        stage_done = '0;
        if (r == rst_r && s == 0) begin
          rst = 1'b0;
          tick();
          rst = 1'b1;
          outcome = 2;
          return;
        end
        for (int w = 1; w <= TO + 1; w++) begin
          if (r == bad_r && s == bad_s && w == bad_w) begin
            stage_done = NS'(1) << ((s + 1) % NS);
            start = 1'b0;
            push(EV_ERR, s, r, cyc + 1);
            tick();
            stage_done = '0;
            outcome = 1;
            return;
          end
          if (dly[r][s] == w) begin
            stage_done = NS'(1) << s;
            start = 1'b0;
            if (s < NS - 1)      push(EV_EN, s + 1, r, cyc + 2);
            else if (r < NR - 1) push(EV_EN, 0, r + 1, cyc + 2);
            else                 push(EV_DONE, NS - 1, NR - 1, cyc + 2);
            tick();
            stage_done = '0;
            tick();
            break;
          end
          if (w == TO + 1) begin
            start = 1'b0;
            push(EV_ERR, s, r, cyc + 1);
            tick();
            outcome = 1;
            return;
          end
          start = 1'($urandom_range(0, 1));
          tick();
        end
      end
    end
    tick();
  endtask

  task automatic check_idle_after(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_round_idx"}, round_idx, 0);
    chk({tag, "_stage_idx"}, stage_idx, 0);
    chk({tag, "_queue_drained"}, q.size(), 0);
  endtask

  task automatic check_error_hold(input int r, input int s);
    start = 1'b1;
    repeat (6) tick();
    start = 1'b0;
    chk("err_error_held", error, 1);
    chk("err_busy", busy, 0);
    chk("err_stage_en", stage_en, 0);
    chk("err_round_frozen", round_idx, r);
    chk("err_stage_frozen", stage_idx, s);
    chk("err_queue_drained", q.size(), 0);
  endtask

  task automatic do_reset();
    q.delete();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    chk("reset_outputs", {stage_en, busy, done, error, round_idx, stage_idx}, 0);
  endtask

  task automatic fill_dly(input int v);
    for (int r = 0; r < NR; r++)
      for (int s = 0; s < NS; s++)
        dly[r][s] = v;
  endtask

  int outcome;

  initial begin
    // Reset then idle, with stray done pulses in the second half.
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stage_done = (i >= 10) ? NS'($urandom) : '0;
      tick();
      chk("idle_outputs", {stage_en, busy, done, error, round_idx, stage_idx}, 0);
    end
    stage_done = '0;

    // Nominal: every stage answers 3 cycles after its enable.
    fill_dly(3);
    run_op(-1, -1, -1, -1, outcome);
    chk("nominal_outcome", outcome, 0);
    check_idle_after("nominal");

    // Fastest responders: start-to-done is 1 + NR*NS*3 cycles.
    fill_dly(1);
    run_op(-1, -1, -1, -1, outcome);
    chk("fast_outcome", outcome, 0);
    check_idle_after("fast");

    // Done arriving exactly when timer == TIMEOUT is accepted.
    fill_dly(2);
    dly[0][1] = TO + 1;
    dly[1][0] = TO + 1;
    run_op(-1, -1, -1, -1, outcome);
    chk("boundary_outcome", outcome, 0);
    chk("boundary_error", error, 0);
    check_idle_after("boundary");

    // Randomized responder delays.
    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < NR; r++)
        for (int s = 0; s < NS; s++)
          dly[r][s] = $urandom_range(1, 6);
      run_op(-1, -1, -1, -1, outcome);
      chk("random_outcome", outcome, 0);
      check_idle_after("random");
    end

    // Timeout: stage 1 of round 0 never answers.
    fill_dly(2);
    dly[0][1] = 0;
    run_op(-1, -1, -1, -1, outcome);
    chk("timeout_outcome", outcome, 1);
    check_error_hold(0, 1);
    do_reset();

    // Protocol fault: stage 0 done while stage 1 is active.
    fill_dly(5);
    run_op(0, 1, 2, -1, outcome);
    chk("fault_outcome", outcome, 1);
    check_error_hold(0, 1);
    do_reset();

    // Reset during round 1, then a complete fresh run.
    fill_dly(2);
    run_op(-1, -1, -1, 1, outcome);
    chk("midreset_outcome", outcome, 2);
    chk("midreset_outputs", {stage_en, busy, done, error, round_idx, stage_idx}, 0);
    chk("midreset_queue", q.size(), 0);
    repeat (2) tick();
    for (int r = 0; r < NR; r++)
      for (int s = 0; s < NS; s++)
        dly[r][s] = $urandom_range(1, 4);
    run_op(-1, -1, -1, -1, outcome);
    chk("after_reset_outcome", outcome, 0);
    check_idle_after("after_reset");

    repeat (3) tick();
    chk("final_queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
